// File: rtl/alu_regfile_ctrl.sv
// Button-driven register bank with a shared combinational ALU. Each debounced
// button rise queues a write request, and queued requests are serviced one per cycle, lowest index first.
module alu_regfile_ctrl #(
    parameter int  WIDTH = 4,
    parameter int  NREG  = 4,
    localparam int SELW  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NREG-1:0]       btn,
    input  logic [1:0]            mode,
    input  logic [SELW-1:0]       src_sel,
    input  logic [SELW-1:0]       a_sel,
    input  logic [SELW-1:0]       b_sel,
    input  logic [1:0]            alu_op,
    output logic [NREG*WIDTH-1:0] regs,
    output logic [WIDTH-1:0]      alu_y,
    output logic                  alu_co,
    output logic                  wr_pulse,
    output logic [SELW-1:0]       wr_idx,
    output logic                  flag_co,
    output logic                  flag_z,
    output logic [NREG-1:0]       pend
);
    localparam int NSLOT = 1 << SELW;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_btn_q;
    logic [NREG-1:0]  r_pend;
    logic             r_wr_pulse;
    logic [SELW-1:0]  r_wr_idx;
    logic             r_flag_co;
    logic             r_flag_z;

    logic [WIDTH-1:0] w_rd [NSLOT];
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_alu_co;
    logic [NREG-1:0]  w_rise;
    logic [NREG-1:0]  w_grant;
    logic             w_gnt_any;
    logic [SELW-1:0]  w_gidx;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_wdata;

    // Select slots past NREG exist only so any select value decodes; they read as zero.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_rd
        if (gi < NREG) begin : g_real
            assign w_rd[gi] = r_regs[gi];
        end else begin : g_pad
            assign w_rd[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
        assign regs[gi*WIDTH +: WIDTH] = r_regs[gi];
    end

    assign w_a    = w_rd[a_sel];
    assign w_b    = w_rd[b_sel];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_alu_y  = '0;
        w_alu_co = 1'b0;
        case (alu_op)
            2'b00: begin w_alu_y = w_sum[WIDTH-1:0];  w_alu_co = w_sum[WIDTH];  end
            2'b01: begin w_alu_y = w_diff[WIDTH-1:0]; w_alu_co = w_diff[WIDTH]; end
            2'b10: w_alu_y = w_a & w_b;
            default: w_alu_y = w_a ^ w_b;
        endcase
    end

    assign w_rise    = btn & ~r_btn_q;
    assign w_gnt_any = |r_pend;
    assign w_grant   = r_pend & (~r_pend + NREG'(1));

    always_comb begin
        w_gidx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (r_pend[i]) w_gidx = SELW'(i);
        end
    end

    assign w_cur = w_rd[w_gidx];

    always_comb begin
        w_wdata = w_cur;
        case (mode)
            2'b00: w_wdata = w_cur + WIDTH'(1);
            2'b01: w_wdata = w_cur - WIDTH'(1);
            2'b10: w_wdata = w_alu_y;
            default: w_wdata = w_rd[src_sel];
        endcase
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (RST) begin
                r_regs[gi] <= '0;
            end else if (w_grant[gi]) begin
                r_regs[gi] <= w_wdata;
            end
        end
    end

    // A rise on the channel granted this cycle re-arms it, so that press is not lost.
    always_ff @(posedge clk) begin
        r_btn_q <= btn;
        if (RST) begin
            r_pend     <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
            r_flag_co  <= 1'b0;
            r_flag_z   <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_grant) | w_rise;
            r_wr_pulse <= w_gnt_any;
            if (w_gnt_any) begin
                r_wr_idx <= w_gidx;
                if (mode == 2'b10) begin
                    r_flag_co <= w_alu_co;
                    r_flag_z  <= (w_alu_y == '0);
                end
            end
        end
    end

    assign alu_y    = w_alu_y;
    assign alu_co   = w_alu_co;
    assign wr_pulse = r_wr_pulse;
    assign wr_idx   = r_wr_idx;
    assign flag_co  = r_flag_co;
    assign flag_z   = r_flag_z;
    assign pend     = r_pend;

endmodule

// File: doc/alu_regfile_ctrl.md
Name: alu_regfile_ctrl

Overview:
- Parametrised register bank of NREG registers, each WIDTH bits, with a shared ALU.
- Each register is updated by a rising edge on its own debounced button line.
- Supported updates: increment, decrement, load ALU result, copy from another register.
- Simultaneous presses queue as pending requests, serviced one per cycle, lowest index first. Sits between the debouncers and the seven-segment display driver on the lab board.

Parameters:
- WIDTH, 4: bits per register and ALU datapath width (>=2).
- NREG, 4: number of registers and button channels (2..16).
- SELW, derived = clog2(NREG) (localparam, not overridable): width of register-select fields.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- btn  in  NREG  debounced button levels, one per register; asynchronous to nothing (already in clk domain).
- mode  in  2  update mode: 00 inc, 01 dec, 10 load ALU result, 11 copy from src_sel.
- src_sel  in  SELW  source register for copy mode.
- a_sel  in  SELW  ALU operand A register select.
- b_sel  in  SELW  ALU operand B register select.
- alu_op  in  2  00 A+B, 01 A-B, 10 A&B, 11 A^B.
- regs  out  NREG*WIDTH  flattened register contents, reg i at [i*WIDTH +: WIDTH].
- alu_y  out  WIDTH  combinational ALU result on current registers.
- alu_co  out  1  combinational carry (add) / borrow (sub, 1 when A<B unsigned); 0 for logic ops.
- wr_pulse  out  1  registered, high one cycle after a register write.
- wr_idx  out  SELW  index of the last written register (registered with wr_pulse).
- flag_co  out  1  alu_co captured at the last mode-10 write.
- flag_z  out  1  1 when the value written at the last mode-10 write was zero.
- pend  out  NREG  pending request mask (debug/LED).

Behaviour:
- Reset (RST=1 at an edge):
  - regs, pend, wr_pulse, wr_idx, flag_co, flag_z all go to 0.
  - btn_q loads btn, so a button held through reset does not fire.
  - Reset overrides any pending or in-flight write.
- Edge detect: btn_q <= btn each cycle; rise = btn & ~btn_q.
- Pending: pend <= (pend & ~grant) | rise.
  - A rise on a channel already pending merges and is lost.
  - A rise on the channel being granted in the same cycle re-sets its bit, so the press is kept.
- Grant: one-hot lowest set bit of the registered pend; no grant when pend==0.
- Write at the grant edge to register g:
  - mode 00: reg[g] + 1, wraps 2^WIDTH-1 -> 0.
  - mode 01: reg[g] - 1, wraps 0 -> 2^WIDTH-1.
  - mode 10: alu_y evaluated on pre-write register values.
  - mode 11: reg[src_sel]. src_sel==g leaves the value unchanged but still counts as a write.
- Sampling: mode, src_sel, a_sel, b_sel and alu_op are sampled in the grant cycle, not the press cycle.
- Latency: btn rises before edge E0 -> pend bit set at E0 -> reg written at E1 (if highest priority) -> wr_pulse/wr_idx valid after E1, for one cycle.
  - k simultaneous presses complete on k consecutive edges in ascending index order.
- Flags: only a mode-10 write updates flag_co = alu_co and flag_z = (alu_y==0). Other modes hold the flags.
- ALU: purely combinational on reg[a_sel] and reg[b_sel]; arithmetic is modulo 2^WIDTH. a_sel==b_sel is legal.
- Out-of-range selects (value >= NREG) read as 0 and copy 0.

Test Plan:
- Reset with btn[0] held high, release RST -> no write, wr_pulse stays 0, regs=0.
- WIDTH=4, mode=01, pulse btn[1] -> reg1=0xF at the second edge after the rise; wr_pulse=1 with wr_idx=1 for exactly one cycle.
- reg0=0x9, reg1=0x8, a_sel=0, b_sel=1, alu_op=00, mode=10, press btn[2] -> reg2=0x1, flag_co=1, flag_z=0. Repeat with alu_op=11 and reg1=0x9 -> reg2=0, flag_co=0, flag_z=1.
- mode=00, btn[3:0] all rise in the same cycle -> reg0..reg3 each =1, written on four consecutive edges in order 0,1,2,3; pend goes 1111, 1110, 1100, 1000, 0000.
- Re-press btn[1] in the exact cycle it is granted -> reg1 incremented twice in total. A second rise on btn[3] while still pending -> reg3 incremented once only.
- NREG=8, WIDTH=8, mode=11, src_sel=5 (reg5=0xA5), press btn[7] -> reg7=0xA5. Assert RST in the cycle pend is nonzero -> no write occurs, all outputs 0.
